// File: rtl/frame_loader_pkg.sv
// Shared definitions for the frame loader and the downstream ref/def mux stage.
package frame_loader_pkg;

  localparam int unsigned FRAME_WORDS_DEF = 76800;
  localparam int unsigned BYTE_ADDR_SHIFT = 2;
  localparam logic [31:0] NEW_FRAME_SET   = 32'h1;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Skips 0 and 1 on wrap so frame parity and the ref/def rule stay valid.
  function automatic logic [31:0] next_frame_count(input logic [31:0] count);
    return (count == 32'hFFFF_FFFF) ? 32'd2 : count + 32'd1;
  endfunction

  function automatic logic bram0_is_ref(input logic [31:0] count);
    return (count <= 32'd2) || !count[0];
  endfunction

endpackage

// File: rtl/frame_word_counter.sv
// Word index within the current frame and count of completed frames.
module frame_word_counter
  import frame_loader_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_widx,
  output logic              o_at_last,
  output logic [31:0]       o_frame_counter,
  output logic [31:0]       o_frame_next
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);

  logic [ADDR_W-1:0] r_widx;
  logic [31:0]       r_frame_counter;
  logic              w_at_last;

  assign w_at_last = (r_widx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_widx          <= '0;
      r_frame_counter <= '0;
    end else if (i_advance) begin
      r_widx <= w_at_last ? '0 : r_widx + 1'b1;
      if (w_at_last) r_frame_counter <= next_frame_count(r_frame_counter);
    end
  end

  assign o_widx          = r_widx;
  assign o_at_last       = w_at_last;
  assign o_frame_counter = r_frame_counter;
  assign o_frame_next    = next_frame_count(r_frame_counter);

endmodule

// File: rtl/frame_loader.sv
// Writes alternate stream frames into two BRAMs and stalls until a finished pair is consumed.
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        proc_done,
  output logic [31:0] bram0_addr,
  output logic [31:0] bram0_din,
  output logic [3:0]  bram0_we,
  output logic [31:0] bram1_addr,
  output logic [31:0] bram1_din,
  output logic [3:0]  bram1_we,
  output logic [31:0] frame_counter,
  output logic [31:0] new_frame,
  output logic        frame_err
);

  state_t            r_state, w_state_next;
  logic              r_live;
  logic              w_accept, w_at_last, w_to_bram1;
  logic [ADDR_W-1:0] w_widx;
  logic [31:0]       w_frame_counter, w_frame_next, w_byte_addr;
  logic [31:0]       r_b0_addr, r_b0_din, r_b1_addr, r_b1_din;
  logic [3:0]        r_b0_we, r_b1_we;
  logic              r_frame_err;

  frame_word_counter #(
    .FRAME_WORDS(FRAME_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_cnt (
    .clock          (clock),
    .reset_n        (reset_n),
    .i_advance      (w_accept),
    .o_widx         (w_widx),
    .o_at_last      (w_at_last),
    .o_frame_counter(w_frame_counter),
    .o_frame_next   (w_frame_next)
  );

  assign w_accept    = s_valid & s_ready;
  assign w_to_bram1  = w_frame_counter[0];
  assign w_byte_addr = 32'(w_widx) << BYTE_ADDR_SHIFT;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= LOAD;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_live  <= 1'b1;
    end
  end

  // NOTE: defaulting the next state first keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD: if (w_accept && w_at_last && (w_frame_next >= 32'd2)) w_state_next = HOLD;
      HOLD: if (proc_done) w_state_next = LOAD;
      default: w_state_next = LOAD;
    endcase
  end

  always_comb begin
    s_ready   = r_live && (r_state == LOAD);
    new_frame = (r_state == HOLD) ? NEW_FRAME_SET : 32'h0;
  end

  // NOTE: BRAM port registers are plain flops, so they reset cleanly to zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_b0_addr   <= '0;
      r_b0_din    <= '0;
      r_b0_we     <= '0;
      r_b1_addr   <= '0;
      r_b1_din    <= '0;
      r_b1_we     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_b0_we <= '0;
      r_b1_we <= '0;
      if (w_accept) begin
        if (w_to_bram1) begin
          r_b1_addr <= w_byte_addr;
          r_b1_din  <= s_data;
          r_b1_we   <= 4'hF;
        end else begin
          r_b0_addr <= w_byte_addr;
          r_b0_din  <= s_data;
          r_b0_we   <= 4'hF;
        end
        if (s_last != w_at_last) r_frame_err <= 1'b1;
      end
    end
  end

  assign bram0_addr    = r_b0_addr;
  assign bram0_din     = r_b0_din;
  assign bram0_we      = r_b0_we;
  assign bram1_addr    = r_b1_addr;
  assign bram1_din     = r_b1_din;
  assign bram1_we      = r_b1_we;
  assign frame_counter = w_frame_counter;
  assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader with 8-word frames and hand-computed expectations.
module tb_frame_loader;

  logic        clock = 1'b0;
  logic        reset_n, s_valid, s_last, s_ready, proc_done, frame_err;
  logic [31:0] s_data, bram0_addr, bram0_din, bram1_addr, bram1_din;
  logic [31:0] frame_counter, new_frame;
  logic [3:0]  bram0_we, bram1_we;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_addr [2];
  logic [31:0] exp_din  [2];
  logic        e_err;

  always #5 clock = ~clock;

  frame_loader #(.FRAME_WORDS(8), .ADDR_W(3)) dut (
    .clock(clock), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .proc_done(proc_done),
    .bram0_addr(bram0_addr), .bram0_din(bram0_din), .bram0_we(bram0_we),
    .bram1_addr(bram1_addr), .bram1_din(bram1_din), .bram1_we(bram1_we),
    .frame_counter(frame_counter), .new_frame(new_frame), .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_we", {24'd0, bram0_we, bram1_we}, 32'd0);
    check("rst_addr0", bram0_addr, 32'd0);
    check("rst_addr1", bram1_addr, 32'd0);
    check("rst_din", bram0_din | bram1_din, 32'd0);
    check("rst_count", frame_counter, 32'd0);
    check("rst_newfr", new_frame, 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    exp_addr = '{32'd0, 32'd0};
    exp_din  = '{32'd0, 32'd0};
    e_err    = 1'b0;
  endtask

  // Feeds words first..first+count-1 back to back; s_last only on word last_at.
  task automatic feed(input logic [31:0] base, input int first, input int count,
                      input int last_at, input int bram);
    for (int k = first; k < first + count; k++) begin
      @(negedge clock);
      s_valid = 1'b1;
      s_data  = base + 32'(k);
      s_last  = (k == last_at);
      check("ready_in", 32'(s_ready), 32'd1);
      @(posedge clock);
      #1;
      exp_addr[bram] = 32'(k) * 4;
      exp_din[bram]  = base + 32'(k);
      e_err = e_err | ((k == last_at) != (k == 7));
      check(bram ? "we1" : "we0", 32'(bram ? bram1_we : bram0_we), 32'hF);
      check("we_other", 32'(bram ? bram0_we : bram1_we), 32'd0);
      check("addr0", bram0_addr, exp_addr[0]);
      check("addr1", bram1_addr, exp_addr[1]);
      check("din0", bram0_din, exp_din[0]);
      check("din1", bram1_din, exp_din[1]);
      check("err", 32'(frame_err), 32'(e_err));
    end
  endtask

  task automatic expect_end(input logic [31:0] cnt, input logic pair);
    check("count", frame_counter, cnt);
    check("newfr", new_frame, pair ? 32'h1 : 32'h0);
    check("ready_end", 32'(s_ready), pair ? 32'd0 : 32'd1);
  endtask

  task automatic handoff();
    @(negedge clock);
    s_valid   = 1'b0;
    s_last    = 1'b0;
    proc_done = 1'b1;
    @(posedge clock);
    #1;
    check("hand_newfr", new_frame, 32'h0);
    check("hand_ready", 32'(s_ready), 32'd1);
    @(negedge clock);
    proc_done = 1'b0;
  endtask

  initial begin
    int writes;
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; proc_done = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values();
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("ready_after_rst", 32'(s_ready), 32'd1);

    feed(32'h100, 0, 8, 7, 0);            // frame 1 -> BRAM_0
    expect_end(32'd1, 1'b0);
    feed(32'h200, 0, 8, 7, 1);            // frame 2 -> BRAM_1, pair ready
    expect_end(32'd2, 1'b1);
    writes = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if ((bram0_we | bram1_we) != 4'h0) writes++;
    end
    check("hold_writes", 32'(writes), 32'd0);
    check("hold_ready", 32'(s_ready), 32'd0);
    handoff();

    feed(32'h300, 0, 8, 7, 0);            // frame 3 -> BRAM_0
    expect_end(32'd3, 1'b1);
    handoff();
    feed(32'h400, 0, 8, 3, 1);            // frame 4 with s_last misplaced
    expect_end(32'd4, 1'b1);
    handoff();

    feed(32'h500, 0, 5, 7, 0);            // partial frame, then reset
    @(negedge clock);
    s_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check_reset_values();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    feed(32'h600, 0, 8, 7, 0);            // restarts as frame 1
    expect_end(32'd1, 1'b0);

    @(negedge clock);
    s_valid = 1'b0;
    force dut.u_cnt.r_frame_counter = 32'hFFFF_FFFF;
    @(posedge clock);
    #1;
    release dut.u_cnt.r_frame_counter;
    check("forced_count", frame_counter, 32'hFFFF_FFFF);
    feed(32'h700, 0, 4, 7, 1);
    @(negedge clock);
    s_valid   = 1'b0;
    proc_done = 1'b1;                     // ignored in LOAD
    @(posedge clock);
    #1;
    check("load_pd_newfr", new_frame, 32'h0);
    check("load_pd_ready", 32'(s_ready), 32'd1);
    check("load_pd_count", frame_counter, 32'hFFFF_FFFF);
    @(negedge clock);
    proc_done = 1'b0;
    feed(32'h700, 4, 4, 7, 1);
    expect_end(32'd2, 1'b1);              // wrapped past 0 and 1
    handoff();
    feed(32'h800, 0, 8, 7, 0);
    expect_end(32'd3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
